// File: rtl/lock_code_entry.sv
// Keypad-side lock controller: buffers key digits, checks them on ENTER,
// drives unlock/error/lockout status and owns the reprogrammable code.
module lock_code_entry #(
    parameter int DIGITS = 4,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1101,
    parameter int MAX_TRIES = 3,
    parameter int UNLOCK_CYCLES = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_valid,
    input  logic [3:0] key_digit,
    input  logic key_enter,
    input  logic key_clear,
    input  logic prog_mode,
    output logic unlocked,
    output logic error,
    output logic prog_done,
    output logic locked_out,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic [$clog2(MAX_TRIES+1)-1:0] fail_count
);

    localparam int CW = 4 * DIGITS;
    localparam int CNTW = $clog2(DIGITS + 1);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ?
                          UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW = $clog2(TMAX + 1);

    localparam logic [1:0] ENTRY   = 2'd0;
    localparam logic [1:0] OPEN    = 2'd1;
    localparam logic [1:0] LOCKOUT = 2'd2;

    localparam logic [CNTW-1:0] FULL = CNTW'(DIGITS);
    localparam logic [FW-1:0] FMAX = FW'(MAX_TRIES);
    localparam logic [TW-1:0] T_OPEN = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);

    logic [1:0] state, state_n;
    logic [CW-1:0] code_reg, code_n;
    logic [CW-1:0] buffer, buf_n;
    logic [CNTW-1:0] cnt_n;
    logic [FW-1:0] fail_n, fail_inc;
    logic [TW-1:0] timer, timer_n;
    logic err_n, pd_n;

    logic accepting;
    logic do_clear, do_enter, do_digit;
    logic full, match, timer_zero;
    logic [CW-1:0] shifted;

    // Strobe priority (clear > enter > digit); keypad dead in lockout.
    always_comb begin
        accepting = (state != LOCKOUT);
        do_clear = accepting & key_clear;
        do_enter = accepting & key_enter & ~key_clear;
        do_digit = accepting & key_valid & ~key_clear & ~key_enter;
        full = (digit_count == FULL);
        match = full && (buffer == code_reg);
        timer_zero = (timer == '0);
        shifted = (buffer << 4) | CW'(key_digit);
        fail_inc = (fail_count == FMAX) ? fail_count : fail_count + 1'b1;
    end

    // Next-state logic for the FSM, entry buffer, code and counters.
    always_comb begin
        state_n = state;
        buf_n = buffer;
        cnt_n = digit_count;
        code_n = code_reg;
        fail_n = fail_count;
        timer_n = timer;
        err_n = 1'b0;
        pd_n = 1'b0;

        unique case (1'b1)
            do_clear, do_enter: begin
                buf_n = '0;
                cnt_n = '0;
            end
            do_digit && !full: begin
                buf_n = shifted;
                cnt_n = digit_count + 1'b1;
            end
            default: ;
        endcase

        unique case (state)
            ENTRY: begin
                if (do_enter) begin
                    if (match) begin
                        state_n = OPEN;
                        timer_n = T_OPEN;
                        fail_n = '0;
                    end else begin
                        err_n = 1'b1;
                        fail_n = fail_inc;
                        if (fail_inc == FMAX) begin
                            state_n = LOCKOUT;
                            timer_n = T_LOCK;
                        end
                    end
                end
            end
            OPEN: begin
                if (do_enter) begin
                    if (prog_mode && full) begin
                        code_n = buffer;
                        pd_n = 1'b1;
                        timer_n = T_OPEN;
                    end else if (prog_mode) begin
                        // Short entry while programming: keep counting down.
                        timer_n = timer_zero ? timer : timer - 1'b1;
                    end else begin
                        state_n = ENTRY;
                    end
                end else if (timer_zero) begin
                    state_n = ENTRY;
                    buf_n = '0;
                    cnt_n = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    state_n = ENTRY;
                    fail_n = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: begin
                state_n = ENTRY;
                buf_n = '0;
                cnt_n = '0;
            end
        endcase
    end

    // Register state and every output so status changes one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENTRY;
            code_reg <= DEFAULT_CODE;
            buffer <= '0;
            digit_count <= '0;
            fail_count <= '0;
            timer <= '0;
            unlocked <= 1'b0;
            error <= 1'b0;
            prog_done <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state <= state_n;
            code_reg <= code_n;
            buffer <= buf_n;
            digit_count <= cnt_n;
            fail_count <= fail_n;
            timer <= timer_n;
            unlocked <= (state_n == OPEN);
            error <= err_n;
            prog_done <= pd_n;
            locked_out <= (state_n == LOCKOUT);
        end
    end

endmodule

// File: tb/tb_lock_code_entry.sv
// Directed bench for lock_code_entry: opening, failures, lockout,
// strobe priority, reprogramming and asynchronous reset.
module tb_lock_code_entry;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_valid = 1'b0;
    logic [3:0] key_digit = 4'h0;
    logic key_enter = 1'b0;
    logic key_clear = 1'b0;
    logic prog_mode = 1'b0;
    logic unlocked, error, prog_done, locked_out;
    logic [2:0] digit_count;
    logic [1:0] fail_count;

    int n_cmp = 0;
    int n_err = 0;

    lock_code_entry dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_digit(key_digit),
        .key_enter(key_enter),
        .key_clear(key_clear),
        .prog_mode(prog_mode),
        .unlocked(unlocked),
        .error(error),
        .prog_done(prog_done),
        .locked_out(locked_out),
        .digit_count(digit_count),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = d;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic enter();
        @(negedge clk);
        key_enter = 1'b1;
        @(posedge clk);
        #1;
        key_enter = 1'b0;
    endtask

    task automatic code4(input logic [15:0] c);
        press(c[15:12]);
        press(c[11:8]);
        press(c[7:4]);
        press(c[3:0]);
    endtask

    task automatic try_code(input logic [15:0] c);
        code4(c);
        enter();
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        check("rst_unl", 32'(unlocked), 0);
        check("rst_err", 32'(error), 0);
        check("rst_lock", 32'(locked_out), 0);
        check("rst_cnt", 32'(digit_count), 0);
        check("rst_fail", 32'(fail_count), 0);

        // 1: default code opens for 8 cycles
        code4(16'h1101);
        check("t1_cnt4", 32'(digit_count), 4);
        enter();
        check("t1_unl", 32'(unlocked), 1);
        check("t1_fail", 32'(fail_count), 0);
        check("t1_cnt0", 32'(digit_count), 0);
        tick(7);
        check("t1_unl_last", 32'(unlocked), 1);
        tick(1);
        check("t1_unl_off", 32'(unlocked), 0);

        // 2: three failures then lockout
        for (int k = 1; k <= 3; k++) begin
            try_code(16'h1234);
            check("t2_err", 32'(error), 1);
            check("t2_fail", 32'(fail_count), 32'(k));
            check("t2_unl", 32'(unlocked), 0);
        end
        check("t2_lock", 32'(locked_out), 1);
        tick(1);
        check("t2_err_pulse", 32'(error), 0);
        press(4'h5);
        enter();
        check("t2_ign_cnt", 32'(digit_count), 0);
        check("t2_ign_err", 32'(error), 0);
        check("t2_lock_mid", 32'(locked_out), 1);
        tick(12);
        check("t2_lock_last", 32'(locked_out), 1);
        tick(1);
        check("t2_lock_off", 32'(locked_out), 0);
        check("t2_fail_clr", 32'(fail_count), 0);

        // 3: short entry fails; fifth digit dropped
        press(4'h1);
        press(4'h1);
        press(4'h0);
        enter();
        check("t3_short_err", 32'(error), 1);
        check("t3_short_fail", 32'(fail_count), 1);
        code4(16'h1101);
        press(4'h7);
        check("t3_cnt_sat", 32'(digit_count), 4);
        enter();
        check("t3_unl", 32'(unlocked), 1);
        check("t3_fail0", 32'(fail_count), 0);
        tick(8);
        check("t3_unl_off", 32'(unlocked), 0);

        // 4: strobe priority
        press(4'h5);
        check("t4_cnt1", 32'(digit_count), 1);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = 4'h3;
        key_clear = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_clear = 1'b0;
        check("t4_clr_cnt", 32'(digit_count), 0);
        press(4'h1);
        press(4'h1);
        press(4'h0);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = 4'h1;
        key_enter = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_enter = 1'b0;
        check("t4_ent_err", 32'(error), 1);
        check("t4_ent_unl", 32'(unlocked), 0);
        check("t4_ent_cnt", 32'(digit_count), 0);
        check("t4_ent_fail", 32'(fail_count), 1);

        // 5: reprogram, relock, use new code, reset restores default
        try_code(16'h1101);
        check("t5_unl", 32'(unlocked), 1);
        prog_mode = 1'b1;
        try_code(16'h9876);
        check("t5_pd", 32'(prog_done), 1);
        check("t5_pd_unl", 32'(unlocked), 1);
        check("t5_pd_cnt", 32'(digit_count), 0);
        tick(1);
        check("t5_pd_pulse", 32'(prog_done), 0);
        prog_mode = 1'b0;
        enter();
        check("t5_relock", 32'(unlocked), 0);
        check("t5_relock_err", 32'(error), 0);
        try_code(16'h1101);
        check("t5_old_err", 32'(error), 1);
        try_code(16'h9876);
        check("t5_new_unl", 32'(unlocked), 1);
        check("t5_new_fail", 32'(fail_count), 0);

        // 6: async reset mid-OPEN
        press(4'h2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_open_unl", 32'(unlocked), 0);
        check("t6_open_cnt", 32'(digit_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        try_code(16'h9876);
        check("t6_code_lost", 32'(error), 1);
        try_code(16'h1101);
        check("t6_dflt_unl", 32'(unlocked), 1);
        tick(8);

        // 6: async reset mid-LOCKOUT
        for (int k = 0; k < 3; k++) try_code(16'h4444);
        check("t6_lock", 32'(locked_out), 1);
        tick(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_lock_off", 32'(locked_out), 0);
        check("t6_lock_fail", 32'(fail_count), 0);
        check("t6_lock_err", 32'(error), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        try_code(16'h1101);
        check("t6_after_unl", 32'(unlocked), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
